uart_receiver: RTL and testbench

- UART serial-to-parallel receiver. It is the receive end of the link driven by the team's uart_transmitter.
- Frame format: 8N1, LSB first, idle-high line, fixed CLKS_PER_BIT clocks per bit.
- Synchronizes the asynchronous RxD pin, validates the start bit at mid-bit, and samples each data and stop bit at mid-bit.
- Presents each received byte with a one-cycle RX_DV strobe to the handshake/echo logic that feeds the transmitter.

---
 rtl/uart_receiver.sv | 190 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART 8N1 receiver: two-flop input synchronizer, mid-bit sampling, one-cycle strobes.
// Define RX_PARITY_EN to switch the frame to 8E1 with an even-parity check.
module uart_receiver #(
    parameter int unsigned CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       RX_DV,
    output logic [7:0] RXByte,
    output logic       RX_Active,
    output logic       FrameErr,
    output logic       ParityErr
);

    localparam int unsigned HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfCnt = CntW'(HALF_BIT);
    localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StCleanup
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StCleanup
    } state_e;
`endif

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shreg;
    logic [7:0]      r_rx_byte;
    logic            r_rx_dv;
    logic            r_active;
    logic            r_frame_err;
    logic            r_rx_meta;
    logic            r_rx_s;
`ifdef RX_PARITY_EN
    logic            r_par_bad;
    logic            r_parity_err;
`endif

    // Synchronizer flops reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_rx_byte   <= '0;
            r_rx_dv     <= 1'b0;
            r_active    <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    if (!r_rx_s) begin
                        r_state  <= StStart;
                        r_active <= 1'b1;
                    end
                end

                StStart: begin
                    if (r_cnt != HalfCnt) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end else begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= StData;
                            r_idx   <= '0;
                        end else begin
                            r_state  <= StIdle;
                            r_active <= 1'b0;
                        end
                    end
                end

                StData: begin
                    if (r_cnt != LastCnt) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end else begin
                        r_cnt          <= '0;
                        r_shreg[r_idx] <= r_rx_s;
                        if (r_idx != 3'd7) begin
                            r_idx <= r_idx + 3'd1;
                        end else begin
                            r_idx <= '0;
`ifdef RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end
                    end
                end

`ifdef RX_PARITY_EN
                StParity: begin
                    if (r_cnt != LastCnt) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end else begin
                        r_cnt     <= '0;
                        r_par_bad <= (r_rx_s != ^r_shreg);
                        r_state   <= StStop;
                    end
                end
`endif

                StStop: begin
                    if (r_cnt != LastCnt) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end else begin
                        r_cnt    <= '0;
                        r_state  <= StCleanup;
                        r_active <= 1'b0;
                        // Framing error wins over parity; the byte is only updated on a clean frame.
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
`ifdef RX_PARITY_EN
                        end else if (r_par_bad) begin
                            r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_rx_byte <= r_shreg;
                            r_rx_dv   <= 1'b1;
                        end
                    end
                end

                StCleanup: begin
                    r_cnt <= '0;
                    // Waiting for a high line keeps a break from re-triggering a start.
                    if (r_rx_s) begin
                        r_state <= StIdle;
                    end
                end

                default: begin
                    r_state  <= StIdle;
                    r_cnt    <= '0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign RX_DV     = r_rx_dv;
    assign RXByte    = r_rx_byte;
    assign RX_Active = r_active;
    assign FrameErr  = r_frame_err;
`ifdef RX_PARITY_EN
    assign ParityErr = r_parity_err;
`else
    assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: scoreboard of expected bytes and strobe cycles,
// checked against what a negedge monitor observes.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;
`ifdef RX_PARITY_EN
    localparam int unsigned LAT = 3 + 7 + 1 + 9 * CPB + CPB;
`else
    localparam int unsigned LAT = 3 + 7 + 1 + 9 * CPB;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       RxD;
    logic       RX_DV;
    logic [7:0] RXByte;
    logic       RX_Active;
    logic       FrameErr;
    logic       ParityErr;

    always #5 clk = ~clk;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .RxD       (RxD),
        .RX_DV     (RX_DV),
        .RXByte    (RXByte),
        .RX_Active (RX_Active),
        .FrameErr  (FrameErr),
        .ParityErr (ParityErr)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every strobe and the RX_Active edges.
    logic [7:0]  q_got[$];
    int unsigned q_got_cyc[$];
    int unsigned n_dv = 0, n_fe = 0, n_pe = 0, n_overlap = 0;
    int unsigned act_rise = 0, act_fall = 0;
    logic        act_prev = 1'b0;

    always @(negedge clk) begin
        if (RX_DV === 1'b1) begin
            q_got.push_back(RXByte);
            q_got_cyc.push_back(cyc);
            n_dv <= n_dv + 1;
        end
        if (FrameErr === 1'b1) n_fe <= n_fe + 1;
        if (ParityErr === 1'b1) n_pe <= n_pe + 1;
        if (int'(RX_DV === 1'b1) + int'(FrameErr === 1'b1) + int'(ParityErr === 1'b1) > 1)
            n_overlap <= n_overlap + 1;
        if (RX_Active === 1'b1 && !act_prev) act_rise <= cyc;
        if (RX_Active === 1'b0 && act_prev) act_fall <= cyc;
        act_prev <= (RX_Active === 1'b1);
    end

    // Scoreboard of expected good frames.
    logic [7:0]  q_exp[$];
    int unsigned q_exp_cyc[$];
    int unsigned exp_dv = 0, exp_fe = 0, exp_pe = 0;
    int unsigned last_t0 = 0;
    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a negedge; good frames are pushed to the scoreboard.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        RxD     = 1'b0;
        last_t0 = cyc;
        if (stop && par_ok) begin
            q_exp.push_back(d);
            q_exp_cyc.push_back(cyc + LAT);
            exp_dv++;
        end
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            idle(CPB);
        end
`ifdef RX_PARITY_EN
        RxD = (^d) ^ ~par_ok;
        idle(CPB);
`endif
        RxD = stop;
        idle(CPB);
    endtask

    task automatic drain();
        while (q_exp.size() > 0) begin
            int unsigned b = 0;
            while (q_got.size() == 0 && b < 400) begin
                @(negedge clk);
                b++;
            end
            if (q_got.size() == 0) begin
                check("rx_dv_seen", q_got.size(), 1);
                void'(q_exp.pop_front());
                void'(q_exp_cyc.pop_front());
            end else begin
                check("rx_byte", q_got.pop_front(), q_exp.pop_front());
                check("rx_dv_cycle", q_got_cyc.pop_front(), q_exp_cyc.pop_front());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        RxD = 1'b1;
        idle(3);
        check("reset_rx_dv", RX_DV, 0);
        check("reset_rxbyte", RXByte, 8'h00);
        check("reset_active", RX_Active, 0);
        check("reset_frame_err", FrameErr, 0);
        check("reset_parity_err", ParityErr, 0);
        rst = 1'b0;
        idle(5);

        // Good frame with exact RX_Active window.
        send_frame(8'hA5, 1'b1, 1'b1);
        check("a5_active_rise", act_rise, last_t0 + 3);
        check("a5_active_fall", act_fall, last_t0 + LAT);
        drain();
        idle(20);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        drain();
        idle(20);

        // Short glitch must not start a frame.
        RxD = 1'b0;
        idle(5);
        RxD = 1'b1;
        idle(30);
        check("glitch_active", RX_Active, 0);
        check("glitch_dv_count", n_dv, exp_dv);
        check("glitch_fe_count", n_fe, exp_fe);
        send_frame(8'h3C, 1'b1, 1'b1);
        drain();
        idle(20);

        // Framing error followed by a stuck-low line.
        send_frame(8'h55, 1'b0, 1'b1);
        exp_fe++;
        idle(40);
        check("fe_count", n_fe, exp_fe);
        check("fe_dv_count", n_dv, exp_dv);
        check("fe_rxbyte_held", RXByte, 8'h3C);
        check("fe_stays_cleanup", RX_Active, 0);
        RxD = 1'b1;
        idle(20);
        send_frame(8'h12, 1'b1, 1'b1);
        drain();
        idle(20);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drain();
        idle(20);
        send_frame(8'h07, 1'b1, 1'b0);
        exp_pe++;
        idle(20);
        check("par_pe_count", n_pe, exp_pe);
        check("par_dv_count", n_dv, exp_dv);
        check("par_rxbyte", RXByte, 8'h07);
`endif

        // Reset in the middle of the data bits abandons the frame.
        RxD = 1'b0;
        idle(CPB);
        RxD = 1'b1;
        idle(CPB);
        RxD = 1'b0;
        idle(CPB + 5);
        check("pre_reset_active", RX_Active, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rx_dv", RX_DV, 0);
        check("midrst_rxbyte", RXByte, 8'h00);
        check("midrst_active", RX_Active, 0);
        check("midrst_frame_err", FrameErr, 0);
        RxD = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(200);
        check("postrst_dv_count", n_dv, exp_dv);
        check("postrst_active", RX_Active, 0);
        send_frame(8'hC3, 1'b1, 1'b1);
        drain();
        idle(20);

        check("final_fe_count", n_fe, exp_fe);
        check("final_pe_count", n_pe, exp_pe);
        check("final_dv_count", n_dv, exp_dv);
        check("strobe_overlap", n_overlap, 0);
        check("extra_bytes", q_got.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
